ahb_lite_arb2: RTL and testbench

Two-port AHB-Lite master arbiter that lets two bus masters share one AHB-Lite slave path, typically the AHB-to-APB bridge in front of the APB peripherals. Each master port has a one-entry address-phase holding register. An arbiter forwards held requests one at a time onto the shared bus. Stalled masters are held off with `HREADYOUTS` low until their transfer completes downstream.

---
 rtl/ahb_arb_pkg.sv | 31 +++
 rtl/ahb_arb_hold_reg.sv | 62 ++++++
 rtl/ahb_lite_arb2.sv | 155 +++++++++++++++
 tb/tb_ahb_lite_arb2.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and the held address-phase record used by ahb_lite_arb2.
// Addresses are held in an ADDR_MAX-bit field, so ADDRWIDTH may not exceed ADDR_MAX.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam int NUM_PORTS = 2;
    localparam int ADDR_MAX  = 32;

    typedef struct packed {
        logic [ADDR_MAX-1:0] addr;
        logic [2:0]          size;
        logic [3:0]          prot;
        logic                write;
        logic                lock;
    } addr_phase_t;

    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

    function automatic logic trans_quiet(input logic [1:0] htrans);
        return (htrans == HTRANS_IDLE) || (htrans == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/ahb_arb_hold_reg.sv
// One-entry address-phase holding register for a single master port of ahb_lite_arb2.
// Generates the port's HREADYOUT/HRESP from the shared data phase when this port owns it.
module ahb_arb_hold_reg
    import ahb_arb_pkg::*;
#(
    parameter int ADDRWIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [1:0]           htrans,
    input  logic [ADDRWIDTH-1:0] haddr,
    input  logic [2:0]           hsize,
    input  logic [3:0]           hprot,
    input  logic                 hwrite,
    input  logic                 hmastlock,
    input  logic                 issue,
    input  logic                 dp_sel,
    input  logic                 hreadym,
    input  logic                 hrespm,
    output logic                 pend,
    output logic                 issued,
    output addr_phase_t          held,
    output logic                 hreadyout,
    output logic                 hresp,
    output logic                 idle_unlock
);

    logic capture;
    logic done;

    // A pending port stalls its master until its own data phase completes downstream.
    assign hreadyout   = dp_sel ? hreadym : ~pend;
    assign hresp       = dp_sel & hrespm;
    assign capture     = hreadyout & trans_active(htrans);
    assign done        = dp_sel & hreadym;
    assign idle_unlock = hreadyout & trans_quiet(htrans) & ~hmastlock;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend   <= 1'b0;
            issued <= 1'b0;
            held   <= '0;
        end else begin
            // Capture may coincide with completion of the previous transfer of this port.
            if (capture) begin
                pend       <= 1'b1;
                issued     <= 1'b0;
                held.addr  <= ADDR_MAX'(haddr);
                held.size  <= hsize;
                held.prot  <= hprot;
                held.write <= hwrite;
                held.lock  <= hmastlock;
            end else if (done) begin
                pend   <= 1'b0;
                issued <= 1'b0;
            end else if (issue) begin
                issued <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_lite_arb2.sv
// Two-port AHB-Lite master arbiter sharing one slave path (e.g. an AHB-to-APB bridge).
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port0 has fixed priority.
module ahb_lite_arb2
    import ahb_arb_pkg::*;
#(
    parameter int ADDRWIDTH = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [3:0]             HTRANSS,
    input  logic [2*ADDRWIDTH-1:0] HADDRS,
    input  logic [5:0]             HSIZES,
    input  logic [5:0]             HBURSTS,
    input  logic [7:0]             HPROTS,
    input  logic [1:0]             HWRITES,
    input  logic [1:0]             HMASTLOCKS,
    input  logic [63:0]            HWDATAS,
    output logic [1:0]             HREADYOUTS,
    output logic [1:0]             HRESPS,
    output logic [31:0]            HRDATAS,
    output logic [1:0]             HTRANSM,
    output logic [ADDRWIDTH-1:0]   HADDRM,
    output logic [2:0]             HSIZEM,
    output logic [2:0]             HBURSTM,
    output logic [3:0]             HPROTM,
    output logic                   HWRITEM,
    output logic                   HMASTLOCKM,
    output logic [31:0]            HWDATAM,
    output logic                   HMASTERM,
    input  logic                   HREADYM,
    input  logic                   HRESPM,
    input  logic [31:0]            HRDATAM
);

    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] issued;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_PORTS-1:0] issue_sel;
    logic [NUM_PORTS-1:0] dp_sel;
    logic [NUM_PORTS-1:0] idle_unlock;
    addr_phase_t          held [NUM_PORTS];
    addr_phase_t          last_ap;
    addr_phase_t          cur_ap;
    logic                 last_master;
    logic                 dp_valid;
    logic                 dp_owner;
    logic                 lock;
    logic                 lock_owner;
    logic                 grant;
    logic                 issue_valid;
    logic                 unused_hbursts;

    // Every forwarded transfer is SINGLE, so the masters' burst type is not needed.
    assign unused_hbursts = ^HBURSTS;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        ahb_arb_hold_reg #(
            .ADDRWIDTH (ADDRWIDTH)
        ) u_hold (
            .HCLK        (HCLK),
            .HRESETn     (HRESETn),
            .htrans      (HTRANSS[2*i +: 2]),
            .haddr       (HADDRS[ADDRWIDTH*i +: ADDRWIDTH]),
            .hsize       (HSIZES[3*i +: 3]),
            .hprot       (HPROTS[4*i +: 4]),
            .hwrite      (HWRITES[i]),
            .hmastlock   (HMASTLOCKS[i]),
            .issue       (issue_sel[i]),
            .dp_sel      (dp_sel[i]),
            .hreadym     (HREADYM),
            .hrespm      (HRESPM),
            .pend        (pend[i]),
            .issued      (issued[i]),
            .held        (held[i]),
            .hreadyout   (HREADYOUTS[i]),
            .hresp       (HRESPS[i]),
            .idle_unlock (idle_unlock[i])
        );
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic last_issued;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_issued <= 1'b1;
        end else if (issue_valid) begin
            last_issued <= grant;
        end
    end
`endif

    // A held lock restricts candidates to the owner, even with the bus idle.
    always_comb begin
        cand = pend & ~issued;
        if (lock) begin
            cand = lock_owner ? (cand & 2'b10) : (cand & 2'b01);
        end
        issue_valid = HREADYM & (cand != 2'b00);
        grant       = 1'b0;
        if (cand == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant = ~last_issued;
`else
            grant = 1'b0;
`endif
        end else begin
            grant = cand[1];
        end
    end

    assign issue_sel = issue_valid ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign dp_sel    = dp_valid ? (dp_owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid    <= 1'b0;
            dp_owner    <= 1'b0;
            lock        <= 1'b0;
            lock_owner  <= 1'b0;
            last_ap     <= '0;
            last_master <= 1'b0;
        end else begin
            if (issue_valid) begin
                dp_valid    <= 1'b1;
                dp_owner    <= grant;
                last_ap     <= held[grant];
                last_master <= grant;
            end else if (dp_valid && HREADYM) begin
                dp_valid <= 1'b0;
            end

            if (issue_valid) begin
                lock       <= held[grant].lock;
                lock_owner <= grant;
            end else if (lock && idle_unlock[lock_owner]) begin
                lock <= 1'b0;
            end
        end
    end

    // Address/control hold their last issued values while the shared bus is idle.
    assign cur_ap     = issue_valid ? held[grant] : last_ap;
    assign HTRANSM    = issue_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDRM     = cur_ap.addr[ADDRWIDTH-1:0];
    assign HSIZEM     = cur_ap.size;
    assign HBURSTM    = HBURST_SINGLE;
    assign HPROTM     = cur_ap.prot;
    assign HWRITEM    = cur_ap.write;
    assign HMASTLOCKM = cur_ap.lock;
    assign HMASTERM   = issue_valid ? grant : last_master;
    assign HWDATAM    = dp_valid ? HWDATAS[32*dp_owner +: 32] : 32'h0;
    assign HRDATAS    = HRDATAM;

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Self-checking bench for ahb_lite_arb2; issue order is checked against a scoreboard queue.
module tb_ahb_lite_arb2;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [3:0]  HTRANSS;
    logic [63:0] HADDRS;
    logic [5:0]  HSIZES;
    logic [5:0]  HBURSTS;
    logic [7:0]  HPROTS;
    logic [1:0]  HWRITES;
    logic [1:0]  HMASTLOCKS;
    logic [63:0] HWDATAS;
    logic [1:0]  HREADYOUTS;
    logic [1:0]  HRESPS;
    logic [31:0] HRDATAS;
    logic [1:0]  HTRANSM;
    logic [31:0] HADDRM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic        HWRITEM;
    logic        HMASTLOCKM;
    logic [31:0] HWDATAM;
    logic        HMASTERM;
    logic        HREADYM;
    logic        HRESPM;
    logic [31:0] HRDATAM;

    // Scoreboard entry: {master, write, addr}
    logic [33:0] exp_q[$];
    logic [33:0] exp_e;
    logic        exp_last;
    int          total = 0;
    int          bad   = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_arb2 #(.ADDRWIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HTRANSS(HTRANSS), .HADDRS(HADDRS),
        .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HWRITES(HWRITES),
        .HMASTLOCKS(HMASTLOCKS), .HWDATAS(HWDATAS), .HREADYOUTS(HREADYOUTS),
        .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HTRANSM(HTRANSM), .HADDRM(HADDRM),
        .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HWRITEM(HWRITEM),
        .HMASTLOCKM(HMASTLOCKM), .HWDATAM(HWDATAM), .HMASTERM(HMASTERM),
        .HREADYM(HREADYM), .HRESPM(HRESPM), .HRDATAM(HRDATAM)
    );

    // Every NONSEQ on the shared bus must match the next expected issue.
    always @(negedge HCLK) begin
        if (HRESETn && HTRANSM == T_NONSEQ) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected got m=%0d w=%0d a=%h exp none", HMASTERM, HWRITEM, HADDRM);
            end else begin
                exp_e = exp_q.pop_front();
                exp_last = exp_e[33];
                if ({HMASTERM, HWRITEM, HADDRM} !== exp_e) begin
                    bad++;
                    $display("FAIL issue_order got m=%0d w=%0d a=%h exp m=%0d w=%0d a=%h",
                             HMASTERM, HWRITEM, HADDRM, exp_e[33], exp_e[32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic req(input int p, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic lk);
        HTRANSS[p*2 +: 2]  = tr;
        HADDRS[p*32 +: 32] = a;
        HSIZES[p*3 +: 3]   = 3'd2;
        HBURSTS[p*3 +: 3]  = 3'd0;
        HPROTS[p*4 +: 4]   = 4'h3;
        HWRITES[p]         = w;
        HMASTLOCKS[p]      = lk;
    endtask

    task automatic push(input int p, input logic w, input logic [31:0] a);
        exp_q.push_back({(p == 1), w, a});
    endtask

    task automatic idle_all();
        req(0, T_IDLE, 32'h0, 1'b0, 1'b0);
        req(1, T_IDLE, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HREADYM = 1'b1; HRESPM = 1'b0; HRDATAM = 32'h0; HWDATAS = 64'h0;
        HTRANSS = 4'h0; HADDRS = 64'h0; HSIZES = 6'h0; HBURSTS = 6'h0; HPROTS = 8'h0;
        HWRITES = 2'b00; HMASTLOCKS = 2'b00; exp_last = 1'b1;
        #1;
        total++; if (HTRANSM !== T_IDLE) begin bad++; $display("FAIL rst_htrans got=%0d exp=0", HTRANSM); end
        total++; if (HREADYOUTS !== 2'b11) begin bad++; $display("FAIL rst_hreadyouts got=%b exp=11", HREADYOUTS); end
        total++; if (HRESPS !== 2'b00) begin bad++; $display("FAIL rst_hresps got=%b exp=00", HRESPS); end
        total++; if ({HADDRM, HSIZEM, HBURSTM, HPROTM, HWRITEM, HMASTLOCKM, HWDATAM, HMASTERM} !== 77'h0) begin
            bad++; $display("FAIL rst_bus got a=%h w=%h m=%0d exp zero", HADDRM, HWDATAM, HMASTERM);
        end
        repeat (2) @(posedge HCLK);
        #2 HRESETn = 1'b1;
    endtask

    task automatic test_single_write();
        next_cycle(); HREADYM = 1'b1; HRESPM = 1'b0;
        req(0, T_NONSEQ, 32'h1000_0004, 1'b1, 1'b0); push(0, 1'b1, 32'h1000_0004);
        #3;
        total++; if (HTRANSM !== T_IDLE) begin bad++; $display("FAIL sw_c0_idle got=%0d exp=0", HTRANSM); end
        next_cycle(); idle_all(); HWDATAS[31:0] = 32'hA5A5_0001;
        #3;
        total++; if (HTRANSM !== T_NONSEQ) begin bad++; $display("FAIL sw_issue got=%0d exp=2", HTRANSM); end
        total++; if (HMASTERM !== 1'b0) begin bad++; $display("FAIL sw_master got=%0d exp=0", HMASTERM); end
        total++; if (HREADYOUTS[0] !== 1'b0) begin bad++; $display("FAIL sw_wait got=%b exp=0", HREADYOUTS[0]); end
        total++; if ({HSIZEM, HBURSTM, HPROTM} !== {3'd2, 3'd0, 4'h3}) begin
            bad++; $display("FAIL sw_ctrl got s=%0d b=%0d p=%h exp s=2 b=0 p=3", HSIZEM, HBURSTM, HPROTM);
        end
        next_cycle();
        #3;
        total++; if (HWDATAM !== 32'hA5A5_0001) begin bad++; $display("FAIL sw_wdata got=%h exp=a5a50001", HWDATAM); end
        total++; if (HREADYOUTS[0] !== 1'b1) begin bad++; $display("FAIL sw_done got=%b exp=1", HREADYOUTS[0]); end
        next_cycle();
        #3;
        total++; if (HTRANSM !== T_IDLE) begin bad++; $display("FAIL sw_after got=%0d exp=0", HTRANSM); end
    endtask

    task automatic test_simultaneous_reads();
        next_cycle();
        req(0, T_NONSEQ, 32'h1000_0000, 1'b0, 1'b0);
        req(1, T_NONSEQ, 32'h1000_0008, 1'b0, 1'b0);
        push(0, 1'b0, 32'h1000_0000); push(1, 1'b0, 32'h1000_0008);
        next_cycle(); idle_all();
        #3;
        total++; if (HREADYOUTS !== 2'b00) begin bad++; $display("FAIL sim_stall got=%b exp=00", HREADYOUTS); end
        total++; if (HMASTERM !== 1'b0) begin bad++; $display("FAIL sim_first got=%0d exp=0", HMASTERM); end
        next_cycle(); HRDATAM = 32'h1111_0000;
        #3;
        total++; if (HREADYOUTS !== 2'b01) begin bad++; $display("FAIL sim_rdy0 got=%b exp=01", HREADYOUTS); end
        total++; if (HRDATAS !== 32'h1111_0000) begin bad++; $display("FAIL sim_rdata0 got=%h exp=11110000", HRDATAS); end
        total++; if (HMASTERM !== 1'b1) begin bad++; $display("FAIL sim_second got=%0d exp=1", HMASTERM); end
        next_cycle(); HRDATAM = 32'h2222_0008;
        #3;
        total++; if (HREADYOUTS !== 2'b11) begin bad++; $display("FAIL sim_rdy1 got=%b exp=11", HREADYOUTS); end
        total++; if (HRDATAS !== 32'h2222_0008) begin bad++; $display("FAIL sim_rdata1 got=%h exp=22220008", HRDATAS); end
    endtask

    task automatic test_lock();
        next_cycle();
        req(1, T_NONSEQ, 32'h1000_0010, 1'b0, 1'b1); push(1, 1'b0, 32'h1000_0010);
        next_cycle();
        req(1, T_NONSEQ, 32'h1000_0010, 1'b1, 1'b1);
        req(0, T_NONSEQ, 32'h1000_0020, 1'b0, 1'b0);
        push(1, 1'b1, 32'h1000_0010); push(0, 1'b0, 32'h1000_0020);
        #3;
        total++; if ({HMASTERM, HMASTLOCKM} !== 2'b11) begin bad++; $display("FAIL lock_rd got m=%0d l=%0d exp m=1 l=1", HMASTERM, HMASTLOCKM); end
        next_cycle(); req(0, T_IDLE, 32'h0, 1'b0, 1'b0); HRDATAM = 32'h0000_00AA;
        #3;
        total++; if (HTRANSM !== T_IDLE) begin bad++; $display("FAIL lock_hold got=%0d exp=0", HTRANSM); end
        total++; if (HREADYOUTS !== 2'b10) begin bad++; $display("FAIL lock_rdy got=%b exp=10", HREADYOUTS); end
        next_cycle(); req(1, T_IDLE, 32'h0, 1'b0, 1'b0); HWDATAS[63:32] = 32'h0000_00AB;
        #3;
        total++; if ({HMASTERM, HMASTLOCKM, HWRITEM} !== 3'b111) begin
            bad++; $display("FAIL lock_wr got m=%0d l=%0d w=%0d exp 1 1 1", HMASTERM, HMASTLOCKM, HWRITEM);
        end
        next_cycle();
        #3;
        total++; if (HTRANSM !== T_IDLE) begin bad++; $display("FAIL lock_still got=%0d exp=0", HTRANSM); end
        total++; if (HWDATAM !== 32'h0000_00AB) begin bad++; $display("FAIL lock_wdata got=%h exp=000000ab", HWDATAM); end
        next_cycle();
        #3;
        total++; if ({HMASTERM, HMASTLOCKM} !== 2'b00) begin bad++; $display("FAIL lock_release got m=%0d l=%0d exp 0 0", HMASTERM, HMASTLOCKM); end
        next_cycle();
        #3;
        total++; if (HREADYOUTS !== 2'b11) begin bad++; $display("FAIL lock_end got=%b exp=11", HREADYOUTS); end
    endtask

    task automatic test_error();
        next_cycle(); req(0, T_NONSEQ, 32'h1000_0030, 1'b1, 1'b0); push(0, 1'b1, 32'h1000_0030);
        next_cycle(); idle_all();
        next_cycle(); HREADYM = 1'b0; HRESPM = 1'b1;
        #3;
        total++; if ({HREADYOUTS, HRESPS} !== 4'b1001) begin bad++; $display("FAIL err_c1 got rdy=%b resp=%b exp rdy=10 resp=01", HREADYOUTS, HRESPS); end
        next_cycle(); HREADYM = 1'b1; HRESPM = 1'b1;
        #3;
        total++; if ({HREADYOUTS, HRESPS} !== 4'b1101) begin bad++; $display("FAIL err_c2 got rdy=%b resp=%b exp rdy=11 resp=01", HREADYOUTS, HRESPS); end
        next_cycle(); HRESPM = 1'b0;
        #3;
        total++; if (HRESPS !== 2'b00) begin bad++; $display("FAIL err_after got=%b exp=00", HRESPS); end
    endtask

    task automatic test_arb_mode();
        logic w;
        next_cycle(); req(0, T_NONSEQ, 32'h1000_0040, 1'b0, 1'b0); push(0, 1'b0, 32'h1000_0040);
        next_cycle(); idle_all();
        next_cycle();
        next_cycle();
        w = RR ? ~exp_last : 1'b0;
        req(0, T_NONSEQ, 32'h1000_0044, 1'b0, 1'b0);
        req(1, T_NONSEQ, 32'h1000_0048, 1'b0, 1'b0);
        if (w) begin
            push(1, 1'b0, 32'h1000_0048); push(0, 1'b0, 32'h1000_0044);
        end else begin
            push(0, 1'b0, 32'h1000_0044); push(1, 1'b0, 32'h1000_0048);
        end
        next_cycle(); idle_all();
        #3;
        total++; if (HMASTERM !== w) begin bad++; $display("FAIL arb_winner got=%0d exp=%0d", HMASTERM, w); end
        next_cycle();
        next_cycle();
        next_cycle();
        #3;
        total++; if (HREADYOUTS !== 2'b11) begin bad++; $display("FAIL arb_end got=%b exp=11", HREADYOUTS); end
    endtask

    task automatic test_back_to_back();
        logic w;
        int   n [2];
        n[0] = 1; n[1] = 1;
        next_cycle();
        w = RR ? ~exp_last : 1'b0;
        req(0, T_NONSEQ, 32'h2000_0000, 1'b1, 1'b0);
        req(1, T_NONSEQ, 32'h2000_0100, 1'b0, 1'b0);
        if (w) begin
            push(1, 1'b0, 32'h2000_0100); push(0, 1'b1, 32'h2000_0000);
        end else begin
            push(0, 1'b1, 32'h2000_0000); push(1, 1'b0, 32'h2000_0100);
        end
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            for (int p = 0; p < 2; p++) begin
                if (HREADYOUTS[p] && c < 8) begin
                    req(p, T_NONSEQ, 32'h2000_0000 + p * 32'h100 + n[p] * 4, (p == 0), 1'b0);
                    push(p, (p == 0), 32'h2000_0000 + p * 32'h100 + n[p] * 4);
                    n[p]++;
                end else begin
                    req(p, T_IDLE, 32'h0, 1'b0, 1'b0);
                end
            end
            #2;
            if (c <= 8) begin
                total++; if (HTRANSM !== T_NONSEQ) begin bad++; $display("FAIL b2b_busy cycle=%0d got=%0d exp=2", c, HTRANSM); end
            end
        end
        next_cycle();
        next_cycle();
        #3;
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        next_cycle(); req(1, T_NONSEQ, 32'h1000_0050, 1'b1, 1'b0); push(1, 1'b1, 32'h1000_0050);
        next_cycle(); idle_all(); HWDATAS[63:32] = 32'h5A5A_0050;
        next_cycle(); HREADYM = 1'b0;
        #2 HRESETn = 1'b0; exp_last = 1'b1;
        #1;
        total++; if ({HREADYOUTS, HRESPS} !== 4'b1100) begin bad++; $display("FAIL rmid_port got rdy=%b resp=%b exp rdy=11 resp=00", HREADYOUTS, HRESPS); end
        total++; if ({HTRANSM, HADDRM, HWRITEM, HWDATAM, HMASTERM} !== 68'h0) begin
            bad++; $display("FAIL rmid_bus got t=%0d a=%h w=%0d d=%h m=%0d exp zero", HTRANSM, HADDRM, HWRITEM, HWDATAM, HMASTERM);
        end
        next_cycle();
        next_cycle(); HRESETn = 1'b1; HREADYM = 1'b1;
        next_cycle(); req(0, T_NONSEQ, 32'h1000_0060, 1'b0, 1'b0); push(0, 1'b0, 32'h1000_0060);
        next_cycle(); idle_all();
        #3;
        total++; if ({HTRANSM, HMASTERM} !== {T_NONSEQ, 1'b0}) begin bad++; $display("FAIL rmid_reissue got t=%0d m=%0d exp t=2 m=0", HTRANSM, HMASTERM); end
        next_cycle();
        #3;
        total++; if (HREADYOUTS !== 2'b11) begin bad++; $display("FAIL rmid_done got=%b exp=11", HREADYOUTS); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_simultaneous_reads();
        test_lock();
        test_error();
        test_arb_mode();
        test_back_to_back();
        test_reset_mid();
        next_cycle();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL final_queue got=%0d exp=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
